// File: rtl/dmem_pkg.sv
// Shared types and default widths for the data-memory arbiter.
// State and owner encodings are fixed so waveforms and debug probes stay readable.
package dmem_pkg;

    localparam int DEF_ADDR_W     = 32;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_MEM_LAT    = 2;
    localparam int DEF_STARVE_MAX = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_e;

endpackage

// File: rtl/dmem_arb_pick.sv
// Winner selection between CPU and DMA, with a saturating count of CPU wins
// taken while DMA was waiting; once it saturates, DMA takes the next grant.
module dmem_arb_pick
    import dmem_pkg::*;
#(
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   cpu_req_i,
    input  logic   dma_req_i,
    input  logic   grant_i,
    output owner_e winner_o
);

    localparam int                 SW   = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0]      SMAX = SW'(STARVE_MAX);

    logic [SW-1:0] starve_q;

    always_comb begin
        winner_o = OWN_CPU;
        if (dma_req_i && (!cpu_req_i || starve_q == SMAX)) begin
            winner_o = OWN_DMA;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= '0;
        end else if (grant_i) begin
            if (winner_o == OWN_DMA) begin
                starve_q <= '0;
            end else if (dma_req_i && starve_q != SMAX) begin
                starve_q <= starve_q + SW'(1);
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares a single-port data memory between the pipeline MEM stage and a DMA port.
// state     | meaning
// ST_IDLE   | no access in flight; arbitrate and latch the winner
// ST_ACCESS | memory strobes driven from latches for MEM_LAT cycles
// ST_DONE   | one-cycle completion: CPU unstalls or dma_done pulses
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int MEM_LAT    = DEF_MEM_LAT,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_done,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int              LAT_W    = $clog2(MEM_LAT + 1);
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LAT - 1);

    state_e            state_q;
    owner_e            owner_q;
    owner_e            winner;
    logic [LAT_W-1:0]  lat_q;
    logic              mem_en_q;
    logic              mem_we_q;
    logic              dma_done_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] dma_rdata_q;
    logic              grant;

    assign grant = (state_q == ST_IDLE) && (cpu_req || dma_req);

    dmem_arb_pick #(
        .STARVE_MAX (STARVE_MAX)
    ) u_pick (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu_req_i (cpu_req),
        .dma_req_i (dma_req),
        .grant_i   (grant),
        .winner_o  (winner)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_CPU;
            lat_q       <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            dma_done_q  <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            dma_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (grant) begin
                        owner_q  <= winner;
                        lat_q    <= LAT_LOAD;
                        mem_en_q <= 1'b1;
                        state_q  <= ST_ACCESS;
                        if (winner == OWN_DMA) begin
                            mem_we_q <= dma_we;
                            addr_q   <= dma_addr;
                            wdata_q  <= dma_wdata;
                        end else begin
                            mem_we_q <= cpu_we;
                            addr_q   <= cpu_addr;
                            wdata_q  <= cpu_wdata;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (lat_q == '0) begin
                        mem_en_q   <= 1'b0;
                        mem_we_q   <= 1'b0;
                        dma_done_q <= (owner_q == OWN_DMA);
                        state_q    <= ST_DONE;
                        // Stores leave the owner's read register untouched.
                        if (!mem_we_q) begin
                            if (owner_q == OWN_DMA) dma_rdata_q <= mem_rdata;
                            else                    cpu_rdata_q <= mem_rdata;
                        end
                    end else begin
                        lat_q <= lat_q - LAT_W'(1);
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q  <= ST_IDLE;
                    mem_en_q <= 1'b0;
                    mem_we_q <= 1'b0;
                end
            endcase
        end
    end

    assign cpu_stall = cpu_req && !(state_q == ST_DONE && owner_q == OWN_CPU);
    assign cpu_rdata = cpu_rdata_q;
    assign dma_rdata = dma_rdata_q;
    assign dma_done  = dma_done_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: expected accesses are queued as stimulus is
// driven and retired by a monitor at each completion (CPU unstall or dma_done).
module tb_dmem_arbiter;
    import dmem_pkg::*;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int LAT  = 2;
    localparam int SMAX = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          cpu_req, cpu_we, cpu_stall;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic          dma_req, dma_we, dma_done;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata, dma_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .ADDR_W (AW), .DATA_W (DW), .MEM_LAT (LAT), .STARVE_MAX (SMAX)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .dma_req   (dma_req),
        .dma_we    (dma_we),
        .dma_addr  (dma_addr),
        .dma_wdata (dma_wdata),
        .dma_rdata (dma_rdata),
        .dma_done  (dma_done),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Memory model: read data is valid only on the last cycle of an access.
    logic [DW-1:0] rd_val = '0;
    int            mem_cyc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) mem_cyc <= 0;
        else        mem_cyc <= mem_en ? mem_cyc + 1 : 0;
    end
    assign mem_rdata = (mem_en && mem_cyc == LAT - 1) ? rd_val : 32'hBAD0_BAD0;

    typedef struct {
        owner_e        own;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("%s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void expect_acc(input owner_e o, input logic we,
                                       input logic [AW-1:0] a, input logic [DW-1:0] d,
                                       input logic [DW-1:0] r);
        exp_t e;
        e.own = o; e.we = we; e.addr = a; e.wdata = d; e.rdata = r;
        exp_q.push_back(e);
    endfunction

    // Monitor: captures each access at mem_en rise, checks stability, retires at completion.
    logic          in_acc = 1'b0;
    logic          cap_we;
    logic [AW-1:0] cap_addr;
    logic [DW-1:0] cap_wdata;
    int            en_len = 0;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            in_acc = 1'b0;
            en_len = 0;
        end else begin
            if (mem_en) begin
                if (!in_acc) begin
                    in_acc    = 1'b1;
                    cap_we    = mem_we;
                    cap_addr  = mem_addr;
                    cap_wdata = mem_wdata;
                    en_len    = 1;
                end else begin
                    en_len++;
                    chk("addr_stable", mem_addr, cap_addr);
                    chk("we_stable", mem_we, cap_we);
                    chk("wdata_stable", mem_wdata, cap_wdata);
                end
            end else begin
                in_acc = 1'b0;
            end
            if (dma_done || (cpu_req && !cpu_stall)) begin
                chk("sb_nonempty", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("owner_is_dma", dma_done, e.own == OWN_DMA);
                    chk("acc_we", cap_we, e.we);
                    chk("acc_addr", cap_addr, e.addr);
                    if (e.we) chk("acc_wdata", cap_wdata, e.wdata);
                    chk("acc_len", en_len, LAT);
                    chk("owner_rdata", dma_done ? dma_rdata : cpu_rdata, e.rdata);
                end
            end
        end
    end

    // Waits for n completions; drops dma_req after each DMA completion and all
    // requests after the last one, driving just after the closing edge.
    task automatic run_grants(input int n);
        int   seen = 0;
        int   t = 0;
        logic was_dma;
        while (seen < n && t < 200) begin
            @(negedge clk);
            t++;
            if (dma_done || (cpu_req && !cpu_stall)) begin
                seen++;
                was_dma = dma_done;
                @(posedge clk);
                #1;
                if (was_dma) dma_req = 1'b0;
                if (seen == n) begin
                    cpu_req = 1'b0;
                    dma_req = 1'b0;
                end
            end
        end
        chk("grants_seen", seen, n);
    endtask

    initial begin
        int t;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_mem_en", mem_en, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_dma_done", dma_done, 1'b0);
        chk("rst_cpu_rdata", cpu_rdata, 32'h0);
        chk("rst_dma_rdata", dma_rdata, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_cpu_stall", cpu_stall, 1'b1);
        cpu_req = 1'b0;
        #1 chk("stall_follows_req", cpu_stall, 1'b0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // CPU load: cycle-exact latency and stall window
        rd_val = 32'hDEAD_BEEF;
        cpu_we = 1'b0; cpu_addr = 32'h10; cpu_req = 1'b1;
        expect_acc(OWN_CPU, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("load_n_en", mem_en, 1'b0);
        chk("load_n_stall", cpu_stall, 1'b1);
        for (int i = 1; i <= LAT; i++) begin
            @(negedge clk);
            chk("load_acc_en", mem_en, 1'b1);
            chk("load_acc_addr", mem_addr, 32'h10);
            chk("load_acc_we", mem_we, 1'b0);
            chk("load_acc_stall", cpu_stall, 1'b1);
        end
        @(negedge clk);
        chk("load_done_en", mem_en, 1'b0);
        chk("load_done_stall", cpu_stall, 1'b0);
        chk("load_done_rdata", cpu_rdata, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        cpu_req = 1'b0;

        // CPU store: read register must keep the previous load value
        rd_val = 32'h0BAD_F00D;
        cpu_we = 1'b1; cpu_addr = 32'h20; cpu_wdata = 32'h1234_5678; cpu_req = 1'b1;
        expect_acc(OWN_CPU, 1'b1, 32'h20, 32'h1234_5678, 32'hDEAD_BEEF);
        run_grants(1);
        chk("store_keeps_rdata", cpu_rdata, 32'hDEAD_BEEF);

        // Both held: four CPU grants, then the starved DMA, then CPU again
        rd_val = 32'hC0DE_0001;
        cpu_we = 1'b0; cpu_addr = 32'h100;
        dma_we = 1'b0; dma_addr = 32'h200;
        cpu_req = 1'b1; dma_req = 1'b1;
        for (int i = 0; i < 4; i++) expect_acc(OWN_CPU, 1'b0, 32'h100, 32'h0, 32'hC0DE_0001);
        expect_acc(OWN_DMA, 1'b0, 32'h200, 32'h0, 32'hC0DE_0001);
        expect_acc(OWN_CPU, 1'b0, 32'h100, 32'h0, 32'hC0DE_0001);
        run_grants(6);
        repeat (8) @(negedge clk);
        chk("order_drained", exp_q.size(), 0);

        // DMA withdraws during its write: access still completes, no regrant
        rd_val = 32'h7777_7777;
        dma_we = 1'b1; dma_addr = 32'h40; dma_wdata = 32'hCAFE_F00D; dma_req = 1'b1;
        expect_acc(OWN_DMA, 1'b1, 32'h40, 32'hCAFE_F00D, 32'hC0DE_0001);
        t = 0;
        while (!mem_en && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("dma_acc_started", mem_en, 1'b1);
        @(posedge clk); #1;
        dma_req = 1'b0;
        repeat (8) @(negedge clk);
        chk("dma_drained", exp_q.size(), 0);
        chk("no_regrant", mem_en, 1'b0);

        // Reset in the second access cycle of a store, then re-grant
        @(posedge clk); #1;
        cpu_we = 1'b1; cpu_addr = 32'h80; cpu_wdata = 32'h55AA_55AA; cpu_req = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("pre_rst_en", mem_en, 1'b1);
        chk("pre_rst_we", mem_we, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_en", mem_en, 1'b0);
        chk("mid_rst_we", mem_we, 1'b0);
        chk("mid_rst_stall", cpu_stall, 1'b1);
        chk("mid_rst_dma_done", dma_done, 1'b0);
        chk("mid_rst_cpu_rdata", cpu_rdata, 32'h0);
        chk("mid_rst_dma_rdata", dma_rdata, 32'h0);
        @(negedge clk); rst_n = 1'b1;
        expect_acc(OWN_CPU, 1'b1, 32'h80, 32'h55AA_55AA, 32'h0);
        run_grants(1);
        repeat (4) @(negedge clk);
        chk("final_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Sequences and shares the single-port data memory between two requesters.
- Requester 1: the pipeline MEM stage (load/store). Requester 2: a DMA/loader port (program/data preload, debug readback).
- Owns all memory enable, write and address strobes.
- Stalls the pipeline while a CPU access is outstanding.
- CPU has priority, with a starvation guard for DMA.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MEM_LAT, 2, cycles the memory needs per access (>=1).
- STARVE_MAX, 4, consecutive CPU grants tolerated while DMA waits (>=1).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cpu_req  in  1  MEM-stage access request; held until served
- cpu_we  in  1  1 = store, 0 = load
- cpu_addr  in  ADDR_W  ALU-computed address
- cpu_wdata  in  DATA_W  store data
- cpu_rdata  out  DATA_W  load result; valid in the DONE cycle of a CPU load
- cpu_stall  out  1  freeze pipeline; high while cpu_req is pending and not in its DONE cycle
- dma_req  in  1  DMA request; held until dma_done
- dma_we  in  1  DMA write enable
- dma_addr  in  ADDR_W  DMA address
- dma_wdata  in  DATA_W  DMA write data
- dma_rdata  out  DATA_W  DMA read result, valid with dma_done
- dma_done  out  1  one-cycle completion pulse
- mem_en  out  1  memory active
- mem_we  out  1  memory write strobe
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid on the last ACCESS cycle

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE; latency counter = 0; starvation counter = 0.
  - mem_en, mem_we and dma_done are 0; mem_addr, mem_wdata, cpu_rdata and dma_rdata are 0.
  - cpu_stall = cpu_req (combinational).
- States are IDLE, ACCESS and DONE.
- IDLE:
  - If any request is present, arbitrate, latch owner/we/addr/wdata from the winner, load the counter with MEM_LAT-1, and go to ACCESS.
  - Otherwise stay in IDLE.
- Arbitration:
  - Only CPU requests: CPU wins. Only DMA requests: DMA wins.
  - Both request: CPU wins unless starve_cnt == STARVE_MAX, in which case DMA wins.
- Starvation counter:
  - Increments (saturating at STARVE_MAX) on each CPU grant while dma_req is high.
  - Clears on any DMA grant.
- ACCESS:
  - mem_en = 1; mem_we = latched we; mem_addr/mem_wdata = latched values, stable for all MEM_LAT cycles.
  - Counter decrements each cycle.
  - When the counter reaches 0: capture mem_rdata into the owner's rdata register (loads only; rdata is unchanged on writes) and go to DONE.
- DONE (one cycle):
  - mem_en = 0.
  - CPU owner: cpu_stall = 0 this cycle, so the pipeline advances at the closing edge.
  - DMA owner: dma_done = 1.
  - Next state is always IDLE.
- Latency:
  - Request first seen in IDLE at cycle N: ACCESS spans N+1..N+MEM_LAT, DONE is at N+MEM_LAT+1.
  - Throughput is one access per MEM_LAT+2 cycles.
- cpu_stall = cpu_req and not (state == DONE and owner == CPU).
  - A CPU request blocked by a DMA access stays stalled throughout that DMA access.
- Request withdrawn mid-ACCESS: the access completes; stores are never aborted.
  - DONE still pulses dma_done (DMA owner) or produces the non-stall cycle (CPU owner).
  - Requester inputs are ignored after the latch.
- Reset asserted mid-ACCESS: immediate return to IDLE with mem_en/mem_we low; any in-flight write is abandoned.
- A new request seen in the DONE cycle is not granted until the following IDLE cycle.

Decomposition:
- Shared package dmem_pkg:
  - state encoding (IDLE=0, ACCESS=1, DONE=2);
  - owner IDs (OWN_CPU=0, OWN_DMA=1);
  - default widths.
- Sub-module dmem_arb_pick: combinational winner selection plus the registered saturating starvation counter.
  - Inputs: cpu_req, dma_req, grant strobe.
  - Output: winner.
- FSM, latency counter and datapath latches stay in dmem_arbiter.

Test Plan:
- Reset check: assert rst_n=0 mid-run with cpu_req=1 -> mem_en=0, mem_we=0, dma_done=0, rdata regs=0, cpu_stall=1, state IDLE.
- CPU load, MEM_LAT=2: cpu_req=1, we=0, addr=0x10, memory returns 0xDEADBEEF.
  - Expect mem_en high for exactly 2 cycles with mem_addr=0x10.
  - Expect cpu_stall low only in cycle N+3, with cpu_rdata=0xDEADBEEF.
- CPU store: addr=0x20, wdata=0x12345678 -> mem_we=1 for 2 cycles with stable addr/data; cpu_rdata unchanged.
- Simultaneous requests, both held, STARVE_MAX=4 -> grant order CPU, CPU, CPU, CPU, DMA, CPU; dma_done pulses once after the fifth grant.
- DMA drops dma_req during ACCESS of write addr 0x40 -> write completes, dma_done pulses once, no further grant.
- Reset pulse during the second ACCESS cycle of a store -> mem_en and mem_we fall asynchronously; after release the FSM is in IDLE and re-grants the held cpu_req.
